// File: rtl/apb2axi_write_packer_if.sv
// ----------------------------------------------------------------------------
// apb2axi_write_packer_if
// Bundles the two streaming sides of the APB-to-AXI write packer:
//   wr_*        : APB write words entering the packer (valid/ready)
//   wdf_push_*  : packed AXI W beats leaving toward the write-data FIFO
// Modports:
//   slave  : the packer's view (consumes wr_*, produces wdf_push_*)
//   master : the surrounding logic's view (produces wr_*, consumes wdf_push_*)
// ----------------------------------------------------------------------------
interface apb2axi_write_packer_if #(
    parameter int TAG_W  = 4,
    parameter int DATA_W = 64,
    parameter int APB_W  = 32
) ();
    logic                  wr_valid;
    logic                  wr_ready;
    logic [TAG_W-1:0]      wr_tag;
    logic [APB_W-1:0]      wr_data;
    logic [APB_W/8-1:0]    wr_strb;
    logic                  wr_last;

    logic                  wdf_push_valid;
    logic                  wdf_push_ready;
    logic [TAG_W-1:0]      wdf_push_tag;
    logic [DATA_W-1:0]     wdf_push_data;
    logic [DATA_W/8-1:0]   wdf_push_strb;
    logic                  wdf_push_last;

    modport slave (
        input  wr_valid, wr_tag, wr_data, wr_strb, wr_last, wdf_push_ready,
        output wr_ready, wdf_push_valid, wdf_push_tag, wdf_push_data,
               wdf_push_strb, wdf_push_last
    );

    modport master (
        output wr_valid, wr_tag, wr_data, wr_strb, wr_last, wdf_push_ready,
        input  wr_ready, wdf_push_valid, wdf_push_tag, wdf_push_data,
               wdf_push_strb, wdf_push_last
    );
endinterface

// File: rtl/apb2axi_write_packer.sv
// ----------------------------------------------------------------------------
// apb2axi_write_packer
// Collects APB write words per tag and packs them lane-by-lane into AXI W
// beats (data + byte strobes). Each tag owns its own accumulator, lane index
// and beat counter, so words of different tags may interleave freely.
// A beat completes when its last lane fills or wr_last is seen; it is then
// loaded into a single output register that feeds the write-data FIFO.
// Ports:
//   pclk, preset : clock, synchronous active-high reset
//   bus          : wr_* input stream and wdf_push_* output stream (slave side)
//   ovf_err      : 1-cycle pulse, beat limit reached without wr_last
//   ovf_tag      : tag of the most recent overflow
//   tag_busy     : bit t set while tag t holds a partial beat
// ----------------------------------------------------------------------------
module apb2axi_write_packer #(
    parameter int TAG_W     = 4,
    parameter int DATA_W    = 64,
    parameter int APB_W     = 32,
    parameter int MAX_BEATS = 16
) (
    input  logic                     pclk,
    input  logic                     preset,
    apb2axi_write_packer_if.slave    bus,
    output logic                     ovf_err,
    output logic [TAG_W-1:0]         ovf_tag,
    output logic [(2**TAG_W)-1:0]    tag_busy
);
    localparam int N_TAG  = 2**TAG_W;
    localparam int WORDS  = DATA_W / APB_W;
    localparam int SW     = APB_W / 8;
    localparam int DSW    = DATA_W / 8;
    localparam int IDX_W  = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int BEAT_W = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;

    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(WORDS - 1);
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(MAX_BEATS - 1);

    // Per-tag state. Kept in flops because reset must clear every entry.
    logic [DATA_W-1:0] acc_data_reg  [N_TAG];
    logic [DSW-1:0]    acc_strb_reg  [N_TAG];
    logic [IDX_W-1:0]  idx_reg       [N_TAG];
    logic [BEAT_W-1:0] beats_reg     [N_TAG];
    logic [N_TAG-1:0]  busy_reg;

    // Output beat register.
    logic              push_valid_reg;
    logic [TAG_W-1:0]  push_tag_reg;
    logic [DATA_W-1:0] push_data_reg;
    logic [DSW-1:0]    push_strb_reg;
    logic              push_last_reg;
    logic              ovf_err_reg;
    logic [TAG_W-1:0]  ovf_tag_reg;

    logic              wr_ready;
    logic              accept;
    logic [IDX_W-1:0]  cur_idx;
    logic [BEAT_W-1:0] cur_beats;
    logic [DATA_W-1:0] cur_data;
    logic [DSW-1:0]    cur_strb;
    logic [DATA_W-1:0] new_data;
    logic [DSW-1:0]    new_strb;
    logic              beat_done;
    logic              force_last;
    logic              beat_last;

    // The output register can take a new beat when empty or draining this
    // cycle, so a completing word and a push handshake may coincide.
    assign wr_ready = !push_valid_reg || bus.wdf_push_ready;
    assign accept   = bus.wr_valid && wr_ready;

    assign cur_idx   = idx_reg[bus.wr_tag];
    assign cur_beats = beats_reg[bus.wr_tag];
    assign cur_data  = acc_data_reg[bus.wr_tag];
    assign cur_strb  = acc_strb_reg[bus.wr_tag];

    // Lane merge: the addressed lane takes the incoming word; other lanes keep
    // the accumulator contents, which are zero for lanes not yet written.
    genvar gi;
    generate
        for (gi = 0; gi < WORDS; gi++) begin : g_lane
            logic lane_hit;
            assign lane_hit = (cur_idx == IDX_W'(gi));
            assign new_data[gi*APB_W +: APB_W] =
                lane_hit ? bus.wr_data : cur_data[gi*APB_W +: APB_W];
            assign new_strb[gi*SW +: SW] =
                lane_hit ? bus.wr_strb : cur_strb[gi*SW +: SW];
        end
    endgenerate

    assign beat_done  = (cur_idx == IDX_LAST) || bus.wr_last;
    assign force_last = (cur_beats == BEAT_LAST);
    assign beat_last  = bus.wr_last || force_last;

    always_ff @(posedge pclk) begin
        if (preset) begin
            for (int t = 0; t < N_TAG; t++) begin
                acc_data_reg[t] <= '0;
                acc_strb_reg[t] <= '0;
                idx_reg[t]      <= '0;
                beats_reg[t]    <= '0;
            end
            busy_reg       <= '0;
            push_valid_reg <= 1'b0;
            push_tag_reg   <= '0;
            push_data_reg  <= '0;
            push_strb_reg  <= '0;
            push_last_reg  <= 1'b0;
            ovf_err_reg    <= 1'b0;
            ovf_tag_reg    <= '0;
        end else begin
            ovf_err_reg <= 1'b0;

            if (push_valid_reg && bus.wdf_push_ready) begin
                push_valid_reg <= 1'b0;
            end

            if (accept) begin
                if (beat_done) begin
                    push_valid_reg <= 1'b1;
                    push_tag_reg   <= bus.wr_tag;
                    push_data_reg  <= new_data;
                    push_strb_reg  <= new_strb;
                    push_last_reg  <= beat_last;

                    acc_data_reg[bus.wr_tag] <= '0;
                    acc_strb_reg[bus.wr_tag] <= '0;
                    idx_reg[bus.wr_tag]      <= '0;
                    busy_reg[bus.wr_tag]     <= 1'b0;
                    // A last beat (real or forced) ends the transaction, so
                    // the next word of this tag starts counting from zero.
                    beats_reg[bus.wr_tag]    <= beat_last ? '0 : cur_beats + 1'b1;

                    if (force_last && !bus.wr_last) begin
                        ovf_err_reg <= 1'b1;
                        ovf_tag_reg <= bus.wr_tag;
                    end
                end else begin
                    acc_data_reg[bus.wr_tag] <= new_data;
                    acc_strb_reg[bus.wr_tag] <= new_strb;
                    idx_reg[bus.wr_tag]      <= cur_idx + 1'b1;
                    busy_reg[bus.wr_tag]     <= 1'b1;
                end
            end
        end
    end

    assign bus.wr_ready       = wr_ready;
    assign bus.wdf_push_valid = push_valid_reg;
    assign bus.wdf_push_tag   = push_tag_reg;
    assign bus.wdf_push_data  = push_data_reg;
    assign bus.wdf_push_strb  = push_strb_reg;
    assign bus.wdf_push_last  = push_last_reg;
    assign ovf_err            = ovf_err_reg;
    assign ovf_tag            = ovf_tag_reg;
    assign tag_busy           = busy_reg;
endmodule

// File: tb/tb_apb2axi_write_packer.sv
// ----------------------------------------------------------------------------
// tb_apb2axi_write_packer
// Scoreboard bench: expected beats are queued as words are driven and are
// compared when the DUT hands a beat to the write-data FIFO.
// ----------------------------------------------------------------------------
module tb_apb2axi_write_packer;
    logic        pclk = 1'b0;
    logic        preset;
    logic        ovf_err;
    logic [3:0]  ovf_tag;
    logic [15:0] tag_busy;

    int total = 0;
    int bad   = 0;
    int ovf_cnt = 0;
    logic [3:0] ovf_tag_seen = 4'hF;

    typedef struct packed {
        logic [3:0]  tag;
        logic [63:0] data;
        logic [7:0]  strb;
        logic        last;
    } beat_t;

    beat_t exp_q[$];

    apb2axi_write_packer_if #(.TAG_W(4), .DATA_W(64), .APB_W(32)) bus ();

    apb2axi_write_packer #(
        .TAG_W(4), .DATA_W(64), .APB_W(32), .MAX_BEATS(16)
    ) dut (
        .pclk     (pclk),
        .preset   (preset),
        .bus      (bus),
        .ovf_err  (ovf_err),
        .ovf_tag  (ovf_tag),
        .tag_busy (tag_busy)
    );

    always #5 pclk = ~pclk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic expect_beat(input logic [3:0] tag, input logic [63:0] data,
                               input logic [7:0] strb, input logic last);
        beat_t e;
        e.tag = tag; e.data = data; e.strb = strb; e.last = last;
        exp_q.push_back(e);
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [3:0] tag, input logic [31:0] data,
                        input logic [3:0] strb, input logic last);
        int n;
        bus.wr_valid = 1'b1;
        bus.wr_tag   = tag;
        bus.wr_data  = data;
        bus.wr_strb  = strb;
        bus.wr_last  = last;
        n = 0;
        forever begin
            @(negedge pclk);
            if (bus.wr_ready) break;
            n++;
            if (n > 50) begin
                check("send_timeout", 64'd1, 64'd0);
                break;
            end
        end
        @(posedge pclk);
        #1;
        bus.wr_valid = 1'b0;
        bus.wr_last  = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 100; i++) begin
            if (exp_q.size() == 0) break;
            @(posedge pclk);
        end
        #1;
        check("drain_left", 64'(exp_q.size()), 64'd0);
    endtask

    // Output monitor: pops one expectation per handshake.
    always @(negedge pclk) begin
        beat_t e;
        if (!preset && bus.wdf_push_valid && bus.wdf_push_ready) begin
            $display("push tag=%0d data=%h strb=%h last=%0d", bus.wdf_push_tag,
                     bus.wdf_push_data, bus.wdf_push_strb, bus.wdf_push_last);
            if (exp_q.size() == 0) begin
                check("unexpected_push", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("push_tag",  64'(bus.wdf_push_tag),  64'(e.tag));
                check("push_data", bus.wdf_push_data,      e.data);
                check("push_strb", 64'(bus.wdf_push_strb), 64'(e.strb));
                check("push_last", 64'(bus.wdf_push_last), 64'(e.last));
            end
        end
        if (!preset && ovf_err) begin
            ovf_cnt++;
            ovf_tag_seen = ovf_tag;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] held;
        preset             = 1'b1;
        bus.wr_valid       = 1'b0;
        bus.wr_tag         = '0;
        bus.wr_data        = '0;
        bus.wr_strb        = '0;
        bus.wr_last        = 1'b0;
        bus.wdf_push_ready = 1'b1;
        repeat (3) @(posedge pclk);
        #1;
        preset = 1'b0;

        // Reset state
        check("rst_valid",    64'(bus.wdf_push_valid), 64'd0);
        check("rst_data",     bus.wdf_push_data,       64'd0);
        check("rst_strb",     64'(bus.wdf_push_strb),  64'd0);
        check("rst_last",     64'(bus.wdf_push_last),  64'd0);
        check("rst_tag",      64'(bus.wdf_push_tag),   64'd0);
        check("rst_ovf",      64'(ovf_err),            64'd0);
        check("rst_ovf_tag",  64'(ovf_tag),            64'd0);
        check("rst_busy",     64'(tag_busy),           64'd0);
        check("rst_wr_ready", 64'(bus.wr_ready),       64'd1);

        // Tag 3 two full words -> one beat, not last
        send(4'd3, 32'h1111_1111, 4'hF, 1'b0);
        check("t3_busy",  64'(tag_busy),           64'h0008);
        check("t3_novld", 64'(bus.wdf_push_valid), 64'd0);
        expect_beat(4'd3, 64'h2222_2222_1111_1111, 8'hFF, 1'b0);
        send(4'd3, 32'h2222_2222, 4'hF, 1'b0);
        check("t3_idle", 64'(tag_busy), 64'h0000);
        drain();

        // Tag 1 single word with last -> push next cycle, upper lane zero
        expect_beat(4'd1, 64'h0000_0000_AAAA_5555, 8'h03, 1'b1);
        send(4'd1, 32'hAAAA_5555, 4'h3, 1'b1);
        check("t1_latency", 64'(bus.wdf_push_valid), 64'd1);
        drain();

        // Interleave tags 2 and 5
        expect_beat(4'd2, 64'hCCCC_0002_AAAA_0002, 8'hFF, 1'b0);
        expect_beat(4'd5, 64'hDDDD_0005_BBBB_0005, 8'hFF, 1'b0);
        send(4'd2, 32'hAAAA_0002, 4'hF, 1'b0);
        send(4'd5, 32'hBBBB_0005, 4'hF, 1'b0);
        check("il_busy", 64'(tag_busy), 64'h0024);
        send(4'd2, 32'hCCCC_0002, 4'hF, 1'b0);
        send(4'd5, 32'hDDDD_0005, 4'hF, 1'b0);
        drain();

        // Back-pressure: beat held while ready low
        bus.wdf_push_ready = 1'b0;
        expect_beat(4'd6, 64'h6666_0001_6666_0000, 8'hFF, 1'b0);
        send(4'd6, 32'h6666_0000, 4'hF, 1'b0);
        send(4'd6, 32'h6666_0001, 4'hF, 1'b0);
        held = bus.wdf_push_data;
        for (int i = 0; i < 5; i++) begin
            @(negedge pclk);
            check("hold_wr_ready", 64'(bus.wr_ready),       64'd0);
            check("hold_valid",    64'(bus.wdf_push_valid), 64'd1);
            check("hold_data",     bus.wdf_push_data,       64'h6666_0001_6666_0000);
        end
        check("hold_stable", bus.wdf_push_data, held);
        @(posedge pclk);
        #1;
        bus.wdf_push_ready = 1'b1;
        @(negedge pclk);
        check("release_wr_ready", 64'(bus.wr_ready), 64'd1);
        @(posedge pclk);
        #1;
        drain();

        // Overflow: 33 words on tag 0 without last
        for (int k = 0; k < 16; k++) begin
            expect_beat(4'd0, {32'h1000_0000 + 32'(2*k+1), 32'h1000_0000 + 32'(2*k)},
                        8'hFF, (k == 15));
        end
        for (int i = 0; i < 33; i++) begin
            send(4'd0, 32'h1000_0000 + 32'(i), 4'hF, 1'b0);
        end
        drain();
        check("ovf_count", 64'(ovf_cnt),      64'd1);
        check("ovf_tag",   64'(ovf_tag_seen), 64'd0);
        check("ovf_busy",  64'(tag_busy),     64'h0001);
        // Word 33 opened a fresh transaction; close it
        expect_beat(4'd0, 64'h1000_0021_1000_0020, 8'hFF, 1'b1);
        send(4'd0, 32'h1000_0021, 4'hF, 1'b1);
        drain();
        check("ovf_count_after", 64'(ovf_cnt), 64'd1);

        // Reset discards a partial beat
        send(4'd4, 32'hDEAD_BEEF, 4'hF, 1'b0);
        check("pre_rst_busy", 64'(tag_busy), 64'h0010);
        preset = 1'b1;
        @(posedge pclk);
        #1;
        preset = 1'b0;
        check("post_rst_busy",  64'(tag_busy),           64'h0000);
        check("post_rst_valid", 64'(bus.wdf_push_valid), 64'd0);
        expect_beat(4'd4, 64'h89AB_CDEF_0123_4567, 8'hFF, 1'b0);
        send(4'd4, 32'h0123_4567, 4'hF, 1'b0);
        send(4'd4, 32'h89AB_CDEF, 4'hF, 1'b0);
        drain();

        repeat (3) @(posedge pclk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
